// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM-stage load/store unit: opcodes, widths,
// FSM state type and small opcode-decoding helpers.
package mem_lsu_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;
    localparam int OP_W   = 8;

    localparam logic             RST_ENABLE = 1'b0;
    localparam logic [DATA_W-1:0] ZERO_WORD = '0;

    localparam logic [OP_W-1:0] OP_LB  = 8'hE0;
    localparam logic [OP_W-1:0] OP_LBU = 8'hE4;
    localparam logic [OP_W-1:0] OP_LH  = 8'hE1;
    localparam logic [OP_W-1:0] OP_LHU = 8'hE5;
    localparam logic [OP_W-1:0] OP_LW  = 8'hE3;
    localparam logic [OP_W-1:0] OP_SB  = 8'hE8;
    localparam logic [OP_W-1:0] OP_SH  = 8'hE9;
    localparam logic [OP_W-1:0] OP_SW  = 8'hEB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_e;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } mem_size_e;

    function automatic mem_size_e size_of(input logic [OP_W-1:0] op);
        mem_size_e sz;
        case (op)
            OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
            OP_LW, OP_SW:         sz = SZ_WORD;
            default:              sz = SZ_NONE;
        endcase
        return sz;
    endfunction

    function automatic logic is_load(input logic [OP_W-1:0] op);
        return (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
               (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic is_store(input logic [OP_W-1:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Halfwords need an even address, words a multiple of four.
    function automatic logic misaligned(input logic [OP_W-1:0] op, input logic [1:0] off);
        logic bad;
        case (size_of(op))
            SZ_HALF: bad = off[0];
            SZ_WORD: bad = |off;
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-bus interface between the load/store unit (master) and memory (slave).
interface mem_lsu_if;
    import mem_lsu_pkg::*;

    // req is raised with we/addr/sel/wdata stable and held, unchanged, until
    // the slave returns a single-cycle ack; rdata is only valid with ack.
    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [3:0]        sel;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, sel, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, sel, wdata,
        output ack, rdata
    );

endinterface

// File: rtl/mem_lsu_lane_fmt.sv
// Big-endian byte-lane formatting: store-side lane select and replication,
// load-side lane extraction with sign or zero extension.
module mem_lsu_lane_fmt
    import mem_lsu_pkg::*;
(
    input  logic [OP_W-1:0]   req_op_i,
    input  logic [1:0]        req_off_i,
    input  logic [DATA_W-1:0] st_data_i,
    output logic [3:0]        sel_o,
    output logic [DATA_W-1:0] st_wdata_o,
    input  logic [OP_W-1:0]   ld_op_i,
    input  logic [1:0]        ld_off_i,
    input  logic [DATA_W-1:0] ld_rdata_i,
    output logic [DATA_W-1:0] ld_data_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Offset 0 is the most significant lane (sel bit 3, bits [31:24]).
    always_comb begin
        sel_o      = 4'b0000;
        st_wdata_o = ZERO_WORD;
        case (size_of(req_op_i))
            SZ_BYTE: begin
                case (req_off_i)
                    2'd0:    sel_o = 4'b1000;
                    2'd1:    sel_o = 4'b0100;
                    2'd2:    sel_o = 4'b0010;
                    default: sel_o = 4'b0001;
                endcase
                if (is_store(req_op_i)) st_wdata_o = {4{st_data_i[7:0]}};
            end
            SZ_HALF: begin
                sel_o = req_off_i[1] ? 4'b0011 : 4'b1100;
                if (is_store(req_op_i)) st_wdata_o = {2{st_data_i[15:0]}};
            end
            SZ_WORD: begin
                sel_o = 4'b1111;
                if (is_store(req_op_i)) st_wdata_o = st_data_i;
            end
            default: begin
                sel_o      = 4'b0000;
                st_wdata_o = ZERO_WORD;
            end
        endcase
    end

    always_comb begin
        case (ld_off_i)
            2'd0:    ld_byte = ld_rdata_i[31:24];
            2'd1:    ld_byte = ld_rdata_i[23:16];
            2'd2:    ld_byte = ld_rdata_i[15:8];
            default: ld_byte = ld_rdata_i[7:0];
        endcase
        ld_half = ld_off_i[1] ? ld_rdata_i[15:0] : ld_rdata_i[31:16];
    end

    always_comb begin
        case (ld_op_i)
            OP_LB:   ld_data_o = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_data_o = {24'h000000, ld_byte};
            OP_LH:   ld_data_o = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_data_o = {16'h0000, ld_half};
            OP_LW:   ld_data_o = ld_rdata_i;
            default: ld_data_o = ZERO_WORD;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: passes ALU results through, runs one bus
// transaction per aligned load/store while stalling the pipeline.
module mem_lsu
    import mem_lsu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_W-1:0]  wd_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [OP_W-1:0]   aluop_i,
    input  logic [DATA_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] reg2_i,
    mem_lsu_if.master         dbus,
    output logic [REG_W-1:0]  wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              stallreq_o,
    output logic              adel_o,
    output logic              ades_o,
    output lsu_state_e        state_o
);

    lsu_state_e        state_q;
    logic [OP_W-1:0]   op_q;
    logic [1:0]        off_q;
    logic              req_q;
    logic              we_q;
    logic [DATA_W-1:0] addr_q;
    logic [3:0]        sel_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] ld_data_q;

    logic [3:0]        fmt_sel;
    logic [DATA_W-1:0] fmt_wdata;
    logic [DATA_W-1:0] fmt_ld_data;
    logic              in_mem_op;
    logic              in_misaligned;

    assign in_mem_op     = (size_of(aluop_i) != SZ_NONE);
    assign in_misaligned = misaligned(aluop_i, mem_addr_i[1:0]);

    mem_lsu_lane_fmt u_lane_fmt (
        .req_op_i   (aluop_i),
        .req_off_i  (mem_addr_i[1:0]),
        .st_data_i  (reg2_i),
        .sel_o      (fmt_sel),
        .st_wdata_o (fmt_wdata),
        .ld_op_i    (op_q),
        .ld_off_i   (off_q),
        .ld_rdata_i (dbus.rdata),
        .ld_data_o  (fmt_ld_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            off_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= ZERO_WORD;
            sel_q     <= 4'b0000;
            wdata_q   <= ZERO_WORD;
            ld_data_q <= ZERO_WORD;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_mem_op && !in_misaligned) begin
                        state_q <= ST_WAIT;
                        req_q   <= 1'b1;
                        we_q    <= is_store(aluop_i);
                        addr_q  <= {mem_addr_i[31:2], 2'b00};
                        sel_q   <= fmt_sel;
                        wdata_q <= fmt_wdata;
                        op_q    <= aluop_i;
                        off_q   <= mem_addr_i[1:0];
                    end
                end
                ST_WAIT: begin
                    if (dbus.ack) begin
                        ld_data_q <= fmt_ld_data;
                        req_q     <= 1'b0;
                        state_q   <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dbus.req   = req_q;
    assign dbus.we    = we_q;
    assign dbus.addr  = addr_q;
    assign dbus.sel   = sel_q;
    assign dbus.wdata = wdata_q;
    assign state_o    = state_q;

    // Writes are suppressed while a memory op is pending so MEM/WB never sees
    // the address as a result; the load value appears only in DONE.
    always_comb begin
        wd_o       = wd_i;
        wreg_o     = wreg_i;
        wdata_o    = wdata_i;
        stallreq_o = 1'b0;
        adel_o     = 1'b0;
        ades_o     = 1'b0;
        if (rst == RST_ENABLE) begin
            wd_o    = '0;
            wreg_o  = 1'b0;
            wdata_o = ZERO_WORD;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_mem_op) begin
                        wreg_o = 1'b0;
                        if (in_misaligned) begin
                            adel_o = is_load(aluop_i);
                            ades_o = is_store(aluop_i);
                        end else begin
                            stallreq_o = 1'b1;
                        end
                    end
                end
                ST_WAIT: begin
                    wreg_o     = 1'b0;
                    stallreq_o = 1'b1;
                end
                ST_DONE: begin
                    if (is_load(op_q)) wdata_o = ld_data_q;
                    else               wreg_o  = 1'b0;
                end
                default: begin
                    wreg_o = 1'b0;
                end
            endcase
        end
    end

endmodule
